conv3x3_engine: RTL
===================

Name: conv3x3_engine

Overview:
Sequential 3x3 convolution stage that sits directly upstream of the 2x2 max-pooling block. It loads a 3x3 kernel and an IMG x IMG feature map over a single 16-bit stream, then computes the (IMG-K+1)^2 valid-convolution outputs with one multiplier-accumulator. Outputs are emitted row-major as single-cycle strobes that drive the pooling stage's register-load enable. With default parameters, a 6x6 result feeds the 6x6 (n=3) pooling buffer.

Parameters:
IMG, 8, input feature-map side length
K, 3, kernel side length (fixed 3; parameter for readability only)
OUT, IMG-K+1, output side length (derived, 6)
FRAC, 8, fractional bits of weights; accumulator right-shift before saturation

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin new frame; sampled only in IDLE or DONE
din_valid  input  1  din qualifier; a word is accepted when high in LOAD_W/LOAD_IMG
din  input  16  unsigned weights (9 words) then pixels (IMG*IMG words), both row-major
conv_out  output  16  unsigned saturated convolution result
conv_valid  output  1  one-cycle strobe; conv_out valid (drives pooling en_reg)
busy  output  1  high in LOAD_W, LOAD_IMG, MAC, EMIT
done_conv  output  1  high in DONE until next start or reset

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all counters, accumulator, conv_out=0, conv_valid=0, busy=0, done_conv=0. Reset mid-frame abandons the frame; weight/pixel storage contents are don't-care.
- States: IDLE -> LOAD_W on start. LOAD_W: store din into w[widx] on each din_valid, widx 0..8; after the 9th word -> LOAD_IMG. LOAD_IMG: store into pix[r][c], row-major; after word IMG*IMG -> MAC with orow=ocol=0, k=0, acc=0.
- MAC: one tap per cycle, k=0..8 (kr=k/3, kc=k%3), acc += pix[orow+kr][ocol+kc] * w[k]. acc is 36 bits unsigned (32-bit product + 4 guard bits). After k=8 -> EMIT.
- EMIT (1 cycle): conv_valid=1; conv_out = (acc>>FRAC) > 16'hFFFF ? 16'hFFFF : (acc>>FRAC)[15:0]. Advance ocol; at ocol=OUT-1, wrap to 0 and increment orow. Clear acc, k=0. If last output (orow=ocol=OUT-1) -> DONE, else -> MAC.
- Latency: first conv_valid occurs 10 cycles after the clock edge accepting the last pixel. Subsequent strobes are exactly 10 cycles apart. Frame compute = OUT*OUT*10 = 360 cycles.
- conv_out holds its last value between strobes. conv_valid is registered, high only in EMIT.
- DONE: done_conv=1, busy=0. start -> LOAD_W, clearing done_conv in the same edge.
- din_valid outside LOAD_W/LOAD_IMG is ignored. start outside IDLE/DONE is ignored. Gaps in din_valid stall loading with no data loss.
- start and din_valid in the same IDLE cycle: only start is taken; that din word is not captured.

Decomposition:
- Package conv_pkg: state enum (IDLE, LOAD_W, LOAD_IMG, MAC, EMIT, DONE); constants K=3, KTAPS=9, ACC_W=36; saturate-shift function.
- Sub-module conv_mac: 16x16 multiply, 36-bit accumulate with clear/enable, and shift/saturate output. The top level holds the FSM, counters, and storage.

Test Plan:
- Identity kernel (w[4]=256, others 0), pix[r][c]=r*8+c -> 36 strobes; conv_out[i][j]=(i+1)*8+(j+1); first 9, 7th 17, last 54; done_conv asserts the cycle after the 36th strobe.
- Box kernel (all w=256), all pixels 1 -> every conv_out=9; strobes exactly 10 cycles apart; first strobe 10 cycles after the last pixel.
- Saturation: all w=16'hFFFF, all pixels 16'hFFFF -> every conv_out=16'hFFFF.
- din_valid toggled 1-0-1 during load with filler words on the low cycles, plus start pulses while busy -> identity result unchanged; no restart.
- reset_n low during MAC of output 10 -> all outputs 0 in the same cycle. Then a new start plus full load produces a correct 36-output frame.
- Back-to-back frames: start in DONE with a new kernel (w[0]=512) -> conv_out[i][j]=2*pix[i][j]; done_conv drops on start.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution engine.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_W   = 3'd1,
        LOAD_IMG = 3'd2,
        MAC      = 3'd3,
        EMIT     = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int K     = 3;
    localparam int KTAPS = K * K;
    localparam int ACC_W = 36;

    // Drop the fractional weight bits, then clamp anything above 16 bits to all-ones.
    function automatic logic [15:0] sat_shift(input logic [ACC_W-1:0] acc, input int frac);
        logic [ACC_W-1:0] s;
        s = acc >> frac;
        if (|s[ACC_W-1:16]) begin
            return 16'hFFFF;
        end
        return s[15:0];
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Single multiply-accumulator: 16x16 product into a 36-bit unsigned accumulator.
// Latency: one cycle per tap; o_sat reflects the accumulator combinationally.
// Backpressure: none; the caller sequences i_clr / i_en.
module conv_mac
    import conv_pkg::*;
#(
    parameter int FRAC = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sat
);

    logic [ACC_W-1:0] r_acc;
    logic [31:0]      w_prod;

    assign w_prod = 32'(i_a) * 32'(i_b);

    // Accumulator: clear wins over accumulate so an EMIT cycle always starts the next window clean.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    assign o_sat = sat_shift(r_acc, FRAC);

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 valid convolution over an IMG x IMG map, kernel and pixels loaded over one 16-bit stream.
// Latency: 9 MAC cycles + 1 EMIT cycle per output; first strobe 10 cycles after the last pixel.
// Backpressure: none on output; din_valid gaps simply stall loading.
module conv3x3_engine
    import conv_pkg::*;
#(
    parameter int IMG  = 8,
    parameter int FRAC = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        din_valid,
    input  logic [15:0] din,
    output logic [15:0] conv_out,
    output logic        conv_valid,
    output logic        busy,
    output logic        done_conv
);

    localparam int OUT   = IMG - K + 1;
    localparam int PIX_N = IMG * IMG;
    localparam int PIX_W = $clog2(PIX_N);
    localparam int RC_W  = $clog2(IMG);

    localparam logic [3:0]       LAST_W   = 4'(KTAPS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIX_N - 1);
    localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(OUT - 1);
    localparam logic [1:0]       LAST_K   = 2'(K - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_widx;
    logic [PIX_W-1:0] r_pidx;
    logic [1:0]       r_kr;
    logic [1:0]       r_kc;
    logic [RC_W-1:0]  r_orow;
    logic [RC_W-1:0]  r_ocol;

    logic [15:0]      r_w   [KTAPS];
    logic [15:0]      r_pix [PIX_N];

    logic [15:0]      r_conv_out;
    logic             r_conv_valid;
    logic             r_done_conv;

    logic             w_mac_clr;
    logic             w_mac_en;
    logic             w_busy;
    logic             w_last_tap;
    logic             w_last_out;
    logic [PIX_W-1:0] w_paddr;
    logic [3:0]       w_kidx;
    logic [15:0]      w_sat;

    assign w_last_tap = (r_kr == LAST_K) && (r_kc == LAST_K);
    assign w_last_out = (r_orow == LAST_RC) && (r_ocol == LAST_RC);
    assign w_paddr    = PIX_W'((int'(r_orow) + int'(r_kr)) * IMG + int'(r_ocol) + int'(r_kc));
    assign w_kidx     = 4'(int'(r_kr) * K + int'(r_kc));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and MAC sequencing strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_mac_clr   = 1'b0;
        w_mac_en    = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = LOAD_W;
                end
            end
            LOAD_W: begin
                w_busy = 1'b1;
                if (din_valid && (r_widx == LAST_W)) begin
                    w_state_nxt = LOAD_IMG;
                end
            end
            LOAD_IMG: begin
                w_busy = 1'b1;
                if (din_valid && (r_pidx == LAST_PIX)) begin
                    w_state_nxt = MAC;
                    w_mac_clr   = 1'b1;
                end
            end
            MAC: begin
                w_busy   = 1'b1;
                w_mac_en = 1'b1;
                if (w_last_tap) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                w_busy      = 1'b1;
                w_mac_clr   = 1'b1;
                w_state_nxt = w_last_out ? DONE : MAC;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Load indices, kernel tap counters and output position; all rewound when a frame starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_widx <= '0;
            r_pidx <= '0;
            r_kr   <= '0;
            r_kc   <= '0;
            r_orow <= '0;
            r_ocol <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_widx <= '0;
                        r_pidx <= '0;
                        r_kr   <= '0;
                        r_kc   <= '0;
                        r_orow <= '0;
                        r_ocol <= '0;
                    end
                end
                LOAD_W: begin
                    if (din_valid) begin
                        r_widx <= r_widx + 4'd1;
                    end
                end
                LOAD_IMG: begin
                    if (din_valid) begin
                        r_pidx <= r_pidx + PIX_W'(1);
                    end
                end
                MAC: begin
                    if (r_kc == LAST_K) begin
                        r_kc <= '0;
                        r_kr <= (r_kr == LAST_K) ? 2'd0 : r_kr + 2'd1;
                    end else begin
                        r_kc <= r_kc + 2'd1;
                    end
                end
                EMIT: begin
                    r_kr <= '0;
                    r_kc <= '0;
                    if (r_ocol == LAST_RC) begin
                        r_ocol <= '0;
                        r_orow <= r_orow + RC_W'(1);
                    end else begin
                        r_ocol <= r_ocol + RC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Kernel and pixel storage; contents are irrelevant until a full load has happened.
    always_ff @(posedge clk) begin
        if ((r_state == LOAD_W) && din_valid) begin
            r_w[r_widx] <= din;
        end
        if ((r_state == LOAD_IMG) && din_valid) begin
            r_pix[r_pidx] <= din;
        end
    end

    conv_mac #(
        .FRAC (FRAC)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_mac_clr),
        .i_en    (w_mac_en),
        .i_a     (r_pix[w_paddr]),
        .i_b     (r_w[w_kidx]),
        .o_sat   (w_sat)
    );

    // Registered outputs: strobe and result captured from the finished window; done follows DONE by a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conv_out   <= '0;
            r_conv_valid <= 1'b0;
            r_done_conv  <= 1'b0;
        end else begin
            r_conv_valid <= (r_state == EMIT);
            if (r_state == EMIT) begin
                r_conv_out <= w_sat;
            end
            r_done_conv <= (r_state == DONE) && !start;
        end
    end

    assign conv_out   = r_conv_out;
    assign conv_valid = r_conv_valid;
    assign busy       = w_busy;
    assign done_conv  = r_done_conv;

endmodule
